adder_result_accumulator: RTL

- Downstream consumer of the 32-bit full adder: takes each {cout, sum} result as a 33-bit unsigned value and accumulates a frame of N results into a wide accumulator.
- Presents the frame total through a valid/ready output, with a sticky overflow flag.
- Used in the FullAdder32 benchmark datapath to turn adder results into frame checksums that can be compared between the golden model and the post-route netlist.

---
 rtl/adder_result_accumulator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/adder_result_accumulator.sv
// Frame accumulator for 33-bit adder results ({cout, sum}); presents each frame total
// on a valid/ready output with a sticky wrap flag.
module adder_result_accumulator #(
   parameter int ACC_W = 48,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy,
   output logic [LEN_W-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

   function automatic logic [ACC_W-1:0] beat_ext(input logic cout, input logic [31:0] sum);
      logic [ACC_W-1:0] r;
      r       = {ACC_W{1'b0}};
      r[32:0] = {cout, sum};
      return r;
   endfunction

   state_t           state_r, state_next_s;
   logic [ACC_W-1:0] acc_r;
   logic             ovf_r;
   logic [LEN_W-1:0] cnt_r, len_r;
   logic             in_ready_r, out_valid_r, busy_r;
   logic             in_ready_next_s, out_valid_next_s, busy_next_s;
   logic             frame_ok_s, load_s, beat_s, last_s;
   logic [ACC_W:0]   sum_s;

   // Qualifying conditions for frame load and beat acceptance; abort overrides both.
   always_comb begin
      frame_ok_s = start && (frame_len != LEN_ZERO);
      last_s     = ((cnt_r + LEN_ONE) == len_r);
      sum_s      = {1'b0, acc_r} + {1'b0, beat_ext(in_cout, in_sum)};
      if (abort) begin
         load_s = 1'b0;
         beat_s = 1'b0;
      end else begin
         load_s = frame_ok_s && ((state_r == IDLE) || ((state_r == HOLD) && out_ready));
         beat_s = (state_r == ACCUM) && in_valid;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      if (abort) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_next_s = frame_ok_s ? ACCUM : IDLE;
            ACCUM:   state_next_s = (in_valid && last_s) ? HOLD : ACCUM;
            HOLD:    state_next_s = out_ready ? (frame_ok_s ? ACCUM : IDLE) : HOLD;
            default: state_next_s = IDLE;
         endcase
      end
   end

   // Output decode from the upcoming state so the handshake flags come straight off flops.
   always_comb begin
      case (state_next_s)
         IDLE: begin
            in_ready_next_s  = 1'b0;
            out_valid_next_s = 1'b0;
            busy_next_s      = 1'b0;
         end
         ACCUM: begin
            in_ready_next_s  = 1'b1;
            out_valid_next_s = 1'b0;
            busy_next_s      = 1'b1;
         end
         HOLD: begin
            in_ready_next_s  = 1'b0;
            out_valid_next_s = 1'b1;
            busy_next_s      = 1'b1;
         end
         default: begin
            in_ready_next_s  = 1'b0;
            out_valid_next_s = 1'b0;
            busy_next_s      = 1'b0;
         end
      endcase
   end

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= in_ready_next_s;
         out_valid_r <= out_valid_next_s;
         busy_r      <= busy_next_s;
      end
   end

   // Accumulator, sticky wrap flag, beat counter and latched frame length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
         cnt_r <= LEN_ZERO;
         len_r <= LEN_ZERO;
      end else if (abort) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
         cnt_r <= LEN_ZERO;
      end else if (load_s) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
         cnt_r <= LEN_ZERO;
         len_r <= frame_len;
      end else if (beat_s) begin
         acc_r <= sum_s[ACC_W-1:0];
         ovf_r <= ovf_r | sum_s[ACC_W];
         cnt_r <= cnt_r + LEN_ONE;
      end else begin
         acc_r <= acc_r;
         ovf_r <= ovf_r;
         cnt_r <= cnt_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_acc   = acc_r;
   assign out_ovf   = ovf_r;
   assign beat_cnt  = cnt_r;

endmodule
